// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words and presents each finished word for one cycle.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        sysclk,
  input  logic        rstd,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  assign word_last = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));

  // word_data is separate from shreg so the next word can start arriving while it is written.
  always_ff @(posedge sysclk or posedge rstd) begin
    if (rstd) begin
      cnt        <= '0;
      shreg      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= word_last;
      if (clr) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (byte_valid) begin
        shreg <= {shreg[15:0], byte_data};
        cnt   <= cnt + 2'd1;
        if (word_last) word_data <= {shreg, byte_data};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory
// and holds the core in reset until the image has been verified.
//
// state    | meaning
// IDLE     | no load yet, core free
// LEN_HI   | waiting for word count high byte
// LEN_LO   | waiting for word count low byte
// DATA     | receiving instruction words
// CSUM     | waiting for checksum byte
// DONE     | image verified, core released
// ERR      | overflow or bad checksum, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORDS  = 256
) (
  input  logic              sysclk,
  input  logic              rstd,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] WORDS_L = 16'(WORDS);

  state_t      state, next_state;
  logic [7:0]  len_hi;
  logic [15:0] n_len;
  logic [15:0] word_idx;
  logic [7:0]  xsum;
  logic [15:0] n_full;
  logic        xfer;
  logic        data_xfer;
  logic        start_ok;
  logic        word_last;
  logic        next_rx;

  assign xfer      = rx_valid && rx_ready;
  assign data_xfer = xfer && (state == S_DATA);
  assign n_full    = {len_hi, rx_data};
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  word_assembler u_asm (
    .sysclk     (sysclk),
    .rstd       (rstd),
    .clr        (start_ok),
    .byte_valid (data_xfer),
    .byte_data  (rx_data),
    .word_last  (word_last),
    .word_valid (im_we),
    .word_data  (im_wdata)
  );

  always_ff @(posedge sysclk or posedge rstd) begin
    if (rstd) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_HI;
      S_LEN_HI: if (xfer) next_state = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (n_full > WORDS_L)    next_state = S_ERR;
          else if (n_full == '0)   next_state = S_CSUM;
          else                     next_state = S_DATA;
        end
      end
      S_DATA: if (word_last && (word_idx + 16'd1 == n_len)) next_state = S_CSUM;
      S_CSUM: if (xfer) next_state = (rx_data == xsum) ? S_DONE : S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rstd) begin
    if (rstd) begin
      len_hi   <= '0;
      n_len    <= '0;
      word_idx <= '0;
      xsum     <= '0;
      im_addr  <= '0;
    end else if (start_ok) begin
      len_hi   <= '0;
      n_len    <= '0;
      word_idx <= '0;
      xsum     <= '0;
    end else if (xfer && state == S_LEN_HI) begin
      len_hi <= rx_data;
    end else if (xfer && state == S_LEN_LO) begin
      n_len <= n_full;
    end else if (data_xfer) begin
      xsum <= xsum ^ rx_data;
      if (word_last) begin
        im_addr  <= word_idx[ADDR_W-1:0];
        word_idx <= word_idx + 16'd1;
      end
    end
  end

  // Status outputs are registered from next_state so they line up with the state register.
  assign next_rx = (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                   (next_state == S_DATA)   || (next_state == S_CSUM);

  always_ff @(posedge sysclk or posedge rstd) begin
    if (rstd) begin
      rx_ready <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rx_ready <= next_rx;
      cpu_hold <= next_rx || (next_state == S_ERR);
      done     <= (next_state == S_DONE);
      err      <= (next_state == S_ERR);
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Loads a program image into the processor's instruction memory from a byte stream, then releases the processor to run it. It is the writer side of instruction memory, which the fetch stage only reads. It sits between a byte source (UART receiver or testbench driver) and the instruction-memory write port. It holds the processor core in reset for the whole load.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width.
- `WORDS`, 256: capacity in 32-bit words; must be ≤ 2^ADDR_W.

Ports:
- `sysclk`  in  1  single clock; all state changes on its rising edge.
- `rstd`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte; a transfer happens on a cycle where `rx_valid && rx_ready`.
- `im_we`  out  1  one-cycle instruction-memory write strobe.
- `im_addr`  out  ADDR_W  word address of the write.
- `im_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  high while loading or in error; drives processor reset.
- `done`  out  1  high in DONE: image loaded and checksum matched.
- `err`  out  1  high in ERR: length overflow or checksum mismatch.

## Operation
- Stream format, in order:
  - LEN: 16-bit word count N, high byte first.
  - DATA: N words, 4 bytes each, big-endian (first byte goes to bits 31:24).
  - CSUM: 1 byte equal to the XOR of all 4N data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR on `start`: go to LEN_HI, clear the word index, byte index and running XOR, set `cpu_hold`=1, clear `done`/`err`.
- LEN_HI: on transfer, latch N[15:8], go to LEN_LO.
- LEN_LO: on transfer, latch N[7:0] and evaluate N:
  - N > WORDS: go to ERR.
  - N = 0: go to CSUM; the expected checksum is 0.
  - Otherwise: go to DATA.
- DATA:
  - Each transfer shifts the byte into the assembly register and XORs it into the running sum.
  - On the 4th byte of a word, the next cycle has `im_we`=1, `im_addr`=word index and `im_wdata`=the assembled word. The word index then increments.
  - After word N-1 is accepted, go to CSUM.
- CSUM: on transfer, compare the byte with the running XOR. Match: go to DONE. Mismatch: go to ERR.
- DONE: `done`=1, `cpu_hold`=0, `rx_ready`=0.
- ERR: `err`=1, `cpu_hold`=1, `rx_ready`=0.
- `rx_ready`=1 exactly in LEN_HI, LEN_LO, DATA and CSUM. It is never dropped during a write cycle: the assembly register and the `im_wdata` output register are separate.
- `start` during LEN_HI..CSUM is ignored.
- `rx_valid` outside the receiving states is ignored; no data is consumed.
- Arithmetic:
  - Word index is 16 bit, compared with N; `im_addr` is its low ADDR_W bits.
  - No wrap-around is possible, because N ≤ WORDS ≤ 2^ADDR_W.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=0, `done`=0, `err`=0. The assembly register, N, the indices and the XOR are all cleared.
- Reset mid-load aborts immediately. No further `im_we` is issued, and memory contents already written are left as is.
- `start` sampled at cycle t gives `rx_ready`=1 and `cpu_hold`=1 from t+1.
- If the 4th byte of a word transfers at cycle k, then `im_we` is asserted at k+1 only. `im_addr`/`im_wdata` hold their values until the next write.
- With back-to-back bytes, a load takes 2+4N+1 transfer cycles. `done` (or `err`) rises on the cycle after the CSUM transfer; the final `im_we` may coincide with that CSUM transfer.
- An N>WORDS overflow sets `err` on the cycle after the LEN_LO transfer.
- Outputs are registered; there is no combinational path from input to output.

## Structure
- Package `imem_loader_pkg`: state enum, `LEN_BYTES`=2, `BYTES_PER_WORD`=4.
- Sub-module `word_assembler`: shifts bytes into a 32-bit big-endian word and raises a one-cycle `word_valid` plus the word. It has a synchronous clear, driven on `start`.
- The top holds the FSM, N, the word index, the XOR, and the output registers.

## Test plan
- Reset then `start`, stream 00 02 | 12 34 56 78 | 9A BC DE F0 | csum 00:
  - writes 0x12345678 at addr 0 and 0x9ABCDEF0 at addr 1;
  - `done`=1 and `cpu_hold`=0 after the CSUM transfer.
- Same stream with csum 0x01: both writes occur, then `err`=1, `cpu_hold`=1, `done`=0.
- N=0x0101 with WORDS=256: `err`=1 the cycle after LEN_LO, and no `im_we` ever.
- N=0, csum 00: `done`=1 with zero writes. Repeat with csum 0x55: `err`=1.
- Gapped `rx_valid` (a random half of the cycles), N=3: the writes carry the correct words at addrs 0,1,2, each `im_we` is one cycle wide, and `start` pulses mid-load are ignored.
- Assert `rstd` after word 0 of a 3-word load: all outputs return to reset values, and no write follows. A new `start` with a full stream then completes normally.
